// File: rtl/fft_out_bcast_ctrl.sv
// ---------------------------------------------------------------------------
// fft_out_bcast_ctrl
//
// Flow-controlled 1-to-2 broadcast of the 64-bit FFT output stream. Each
// accepted beat is held in a single register. The low half goes to out1 and
// the high half goes to out2. Each half is delivered exactly once, however the
// two consumers stall. The block also checks in1_Tlast against the expected
// frame length and counts completed frames.
//
// Parameters
//   FRAME_LEN  beats per frame (>= 2); sets where in1_Tlast is expected
//   CNT_W      width of frame_cnt
//
// Ports
//   aclk, aresetn          clock and asynchronous active-low reset
//   in1_T{data,valid,last,ready}   64-bit input stream
//   out1_T{data,valid,last,ready}  low half  [31:0]  of the held beat
//   out2_T{data,valid,last,ready}  high half [63:32] of the held beat
//   clr_err                synchronous clear of last_err
//   last_err               sticky Tlast/frame-length mismatch flag
//   frame_done             1-cycle pulse after a Tlast beat left on both sides
//   frame_cnt              completed frame counter, wraps at 2^CNT_W
// ---------------------------------------------------------------------------
module fft_out_bcast_ctrl #(
    parameter int FRAME_LEN = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [63:0]      in1_Tdata,
    input  logic             in1_Tvalid,
    input  logic             in1_Tlast,
    output logic             in1_Tready,
    output logic [31:0]      out1_Tdata,
    output logic             out1_Tvalid,
    output logic             out1_Tlast,
    input  logic             out1_Tready,
    output logic [31:0]      out2_Tdata,
    output logic             out2_Tvalid,
    output logic             out2_Tlast,
    input  logic             out2_Tready,
    input  logic             clr_err,
    output logic             last_err,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    logic [63:0]      data_q, data_d;
    logic             last_q, last_d;
    logic             full_q, full_d;
    logic             sent1_q, sent1_d;
    logic             sent2_q, sent2_d;
    logic [IDX_W-1:0] beat_idx_q, beat_idx_d;
    logic             last_err_q, last_err_d;
    logic             frame_done_q, frame_done_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic fire1, fire2, done1, done2, rel, accept, exp_last, frame_end;

    // Handshake decode. A branch that has already taken the held beat (sentN)
    // counts as done, so the register frees once the slower branch fires.
    // in1_Tready depends only on state and the out readies, never on in1_Tvalid.
    always_comb begin
        out1_Tvalid = full_q & ~sent1_q;
        out2_Tvalid = full_q & ~sent2_q;
        fire1       = out1_Tvalid & out1_Tready;
        fire2       = out2_Tvalid & out2_Tready;
        done1       = sent1_q | fire1;
        done2       = sent2_q | fire2;
        rel         = full_q & done1 & done2;
        in1_Tready  = ~full_q | rel;
        accept      = in1_Tvalid & in1_Tready;
        exp_last    = (beat_idx_q == LAST_IDX);
        frame_end   = rel & last_q;
    end

    always_comb begin
        data_d       = data_q;
        last_d       = last_q;
        full_d       = full_q;
        sent1_d      = sent1_q;
        sent2_d      = sent2_q;
        beat_idx_d   = beat_idx_q;
        last_err_d   = last_err_q;
        frame_done_d = frame_end;
        frame_cnt_d  = frame_cnt_q + CNT_W'(frame_end);

        // Accept takes priority: it coincides with release when the register
        // is busy, which keeps the stream at one beat per clock.
        if (accept) begin
            data_d  = in1_Tdata;
            last_d  = in1_Tlast;
            full_d  = 1'b1;
            sent1_d = 1'b0;
            sent2_d = 1'b0;
        end else if (rel) begin
            full_d  = 1'b0;
            sent1_d = 1'b0;
            sent2_d = 1'b0;
        end else begin
            if (fire1) sent1_d = 1'b1;
            if (fire2) sent2_d = 1'b1;
        end

        // A new mismatch overrides a simultaneous clear.
        if (clr_err) last_err_d = 1'b0;
        if (accept) begin
            if (in1_Tlast != exp_last) last_err_d = 1'b1;
            // Both an early and a missing Tlast restart the frame at idx 0.
            beat_idx_d = (in1_Tlast | exp_last) ? '0 : beat_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            data_q       <= '0;
            last_q       <= 1'b0;
            full_q       <= 1'b0;
            sent1_q      <= 1'b0;
            sent2_q      <= 1'b0;
            beat_idx_q   <= '0;
            last_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            data_q       <= data_d;
            last_q       <= last_d;
            full_q       <= full_d;
            sent1_q      <= sent1_d;
            sent2_q      <= sent2_d;
            beat_idx_q   <= beat_idx_d;
            last_err_q   <= last_err_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign out1_Tdata = data_q[31:0];
    assign out2_Tdata = data_q[63:32];
    assign out1_Tlast = last_q;
    assign out2_Tlast = last_q;
    assign last_err   = last_err_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_out_bcast_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_out_bcast_ctrl
//
// Directed bench for fft_out_bcast_ctrl (FRAME_LEN=4, CNT_W=3). The reference
// model is a log of every accepted beat plus one delivery index per branch.
// A branch has a pending beat while its index lags the log. The compare
// process checks the DUT against this model on every falling edge. The
// stimulus process also checks some hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_fft_out_bcast_ctrl;

    localparam int FL = 4;
    localparam int CW = 3;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [63:0]   in1_Tdata;
    logic          in1_Tvalid, in1_Tlast, in1_Tready;
    logic [31:0]   out1_Tdata, out2_Tdata;
    logic          out1_Tvalid, out1_Tlast, out1_Tready;
    logic          out2_Tvalid, out2_Tlast, out2_Tready;
    logic          clr_err, last_err, frame_done;
    logic [CW-1:0] frame_cnt;

    always #5 aclk = ~aclk;

    fft_out_bcast_ctrl #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in1_Tdata(in1_Tdata), .in1_Tvalid(in1_Tvalid), .in1_Tlast(in1_Tlast), .in1_Tready(in1_Tready),
        .out1_Tdata(out1_Tdata), .out1_Tvalid(out1_Tvalid), .out1_Tlast(out1_Tlast), .out1_Tready(out1_Tready),
        .out2_Tdata(out2_Tdata), .out2_Tvalid(out2_Tvalid), .out2_Tlast(out2_Tlast), .out2_Tready(out2_Tready),
        .clr_err(clr_err), .last_err(last_err), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } beat_t;

    beat_t         beats[$];
    int            d1, d2, exp_idx;
    logic          exp_err, exp_done;
    logic [CW-1:0] exp_cnt;
    int            done_seen, fire1_seen, fire2_seen;

    always @(negedge aclk) begin
        bit    p1, p2, e_rdy, f1, f2, acc, nxt_done, mism;
        int    old_min, new_min;
        beat_t b;
        if (!aresetn) begin
            d1 = beats.size();
            d2 = beats.size();
            exp_idx = 0; exp_err = 1'b0; exp_done = 1'b0; exp_cnt = '0;
            chk("rst_v1", 64'(out1_Tvalid), 64'(0));
            chk("rst_v2", 64'(out2_Tvalid), 64'(0));
            chk("rst_rdy", 64'(in1_Tready), 64'(1));
            chk("rst_done", 64'(frame_done), 64'(0));
            chk("rst_cnt", 64'(frame_cnt), 64'(0));
            chk("rst_err", 64'(last_err), 64'(0));
        end else begin
            p1 = d1 < beats.size();
            p2 = d2 < beats.size();
            e_rdy = (!p1 || out1_Tready) && (!p2 || out2_Tready);
            chk("v1", 64'(out1_Tvalid), 64'(p1));
            chk("v2", 64'(out2_Tvalid), 64'(p2));
            chk("in_rdy", 64'(in1_Tready), 64'(e_rdy));
            chk("last_err", 64'(last_err), 64'(exp_err));
            chk("frame_done", 64'(frame_done), 64'(exp_done));
            chk("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
            if (p1) begin
                chk("d1", 64'(out1_Tdata), 64'(beats[d1].data[31:0]));
                chk("l1", 64'(out1_Tlast), 64'(beats[d1].last));
            end
            if (p2) begin
                chk("d2", 64'(out2_Tdata), 64'(beats[d2].data[63:32]));
                chk("l2", 64'(out2_Tlast), 64'(beats[d2].last));
            end
            if (frame_done) done_seen++;
            if (out1_Tvalid && out1_Tready) fire1_seen++;
            if (out2_Tvalid && out2_Tready) fire2_seen++;

            // Advance the model to the state after the coming rising edge.
            f1 = p1 && out1_Tready;
            f2 = p2 && out2_Tready;
            acc = in1_Tvalid && e_rdy;
            old_min = (d1 < d2) ? d1 : d2;
            if (f1) d1++;
            if (f2) d2++;
            new_min = (d1 < d2) ? d1 : d2;
            nxt_done = (new_min > old_min) && beats[new_min-1].last;
            if (nxt_done) exp_cnt = exp_cnt + 1'b1;
            exp_done = nxt_done;
            if (clr_err) exp_err = 1'b0;
            if (acc) begin
                mism = (in1_Tlast != (exp_idx == FL-1));
                if (mism) exp_err = 1'b1;
                exp_idx = (in1_Tlast || exp_idx == FL-1) ? 0 : exp_idx + 1;
                b.data = in1_Tdata;
                b.last = in1_Tlast;
                beats.push_back(b);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic        toggle, ph;
    logic [31:0] peek1;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Present one beat and hold it until it is accepted (bounded wait).
    // peek1 records out1_Tdata seen in the accepting cycle.
    task automatic send(input logic [63:0] d, input logic l, output int cyc);
        logic acc;
        acc = 1'b0;
        cyc = 0;
        in1_Tdata = d;
        in1_Tlast = l;
        in1_Tvalid = 1'b1;
        while (!acc && cyc < 50) begin
            if (toggle) begin
                out1_Tready = ph;
                out2_Tready = ~ph;
                ph = ~ph;
            end
            @(negedge aclk);
            acc = in1_Tready;
            peek1 = out1_Tdata;
            step();
            cyc++;
        end
        in1_Tvalid = 1'b0;
        if (!acc) chk("send_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        aresetn = 1'b0; in1_Tdata = '0; in1_Tvalid = 1'b0; in1_Tlast = 1'b0;
        out1_Tready = 1'b1; out2_Tready = 1'b1; clr_err = 1'b0;
        toggle = 1'b0; ph = 1'b0; peek1 = '0;
        done_seen = 0; fire1_seen = 0; fire2_seen = 0;
        @(negedge aclk);
        chk("reset_rdy", 64'(in1_Tready), 64'(1));
        chk("reset_cnt", 64'(frame_cnt), 64'(0));
        step();
        aresetn = 1'b1;
        step();

        // 1: two 4-beat frames at full rate
        done_seen = 0;
        for (int n = 0; n < 8; n++) begin
            send({32'h0000000B, 32'h0000000A + 32'(n)}, (n == 3 || n == 7), cyc);
            chk("t1_b2b", 64'(cyc), 64'(1));
            if (n > 0) chk("t1_out1", 64'(peek1), 64'(32'h0000000A + 32'(n - 1)));
        end
        repeat (3) step();
        chk("t1_cnt", 64'(frame_cnt), 64'(2));
        chk("t1_err", 64'(last_err), 64'(0));
        chk("t1_done", 64'(done_seen), 64'(2));

        // 2: out1 stalled for 3 cycles, out2 ready
        out1_Tready = 1'b0; out2_Tready = 1'b1;
        send(64'h22222222_11111111, 1'b0, cyc);
        in1_Tdata = 64'h44444444_33333333; in1_Tlast = 1'b0; in1_Tvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            chk("t2_rdy", 64'(in1_Tready), 64'(0));
            chk("t2_v1", 64'(out1_Tvalid), 64'(1));
            chk("t2_v2", 64'(out2_Tvalid), 64'(k == 0));
            if (k == 0) chk("t2_d2", 64'(out2_Tdata), 64'(32'h22222222));
            step();
        end
        out1_Tready = 1'b1;
        @(negedge aclk);
        chk("t2_rdy_up", 64'(in1_Tready), 64'(1));
        chk("t2_d1", 64'(out1_Tdata), 64'(32'h11111111));
        step();
        in1_Tvalid = 1'b0;
        @(negedge aclk);
        chk("t2_next1", 64'(out1_Tdata), 64'(32'h33333333));
        chk("t2_next2", 64'(out2_Tdata), 64'(32'h44444444));
        step();
        repeat (2) step();

        // 3: out-of-phase readies over 6 beats (frame idx resumes at 2)
        fire1_seen = 0; fire2_seen = 0;
        toggle = 1'b1; ph = 1'b0;
        for (int t = 0; t < 6; t++)
            send({32'h30000000 + 32'(t), 32'h20000000 + 32'(t)}, (t == 1 || t == 5), cyc);
        repeat (4) begin
            out1_Tready = ph; out2_Tready = ~ph; ph = ~ph;
            step();
        end
        toggle = 1'b0; out1_Tready = 1'b1; out2_Tready = 1'b1;
        repeat (2) step();
        chk("t3_fire1", 64'(fire1_seen), 64'(6));
        chk("t3_fire2", 64'(fire2_seen), 64'(6));
        chk("t3_err", 64'(last_err), 64'(0));
        chk("t3_cnt", 64'(frame_cnt), 64'(4));

        // 4: early Tlast on beat 1, then a correct frame, then clear
        send(64'h1, 1'b0, cyc);
        send(64'h2, 1'b1, cyc);
        @(negedge aclk);
        chk("t4_err_set", 64'(last_err), 64'(1));
        step();
        for (int n = 0; n < 4; n++) send(64'h100 + 64'(n), (n == 3), cyc);
        repeat (2) step();
        chk("t4_cnt", 64'(frame_cnt), 64'(6));
        chk("t4_err_hold", 64'(last_err), 64'(1));
        clr_err = 1'b1; step(); clr_err = 1'b0;
        @(negedge aclk);
        chk("t4_err_clr", 64'(last_err), 64'(0));
        step();

        // 5: missing Tlast, resync, then clear colliding with a mismatch
        for (int n = 0; n < 4; n++) send(64'h200 + 64'(n), 1'b0, cyc);
        @(negedge aclk);
        chk("t5_err_set", 64'(last_err), 64'(1));
        step();
        clr_err = 1'b1; step(); clr_err = 1'b0;
        for (int n = 0; n < 4; n++) send(64'h300 + 64'(n), (n == 3), cyc);
        repeat (2) step();
        chk("t5_resync", 64'(last_err), 64'(0));
        chk("t5_cnt", 64'(frame_cnt), 64'(7));
        clr_err = 1'b1;
        send(64'h400, 1'b1, cyc);
        clr_err = 1'b0;
        @(negedge aclk);
        chk("t5_clr_vs_err", 64'(last_err), 64'(1));
        step();
        repeat (2) step();
        chk("t5_wrap", 64'(frame_cnt), 64'(0));
        send(64'h500, 1'b1, cyc);
        repeat (2) step();
        chk("t5_cnt1", 64'(frame_cnt), 64'(1));

        // 6: reset while holding a beat that out2 has already taken
        out1_Tready = 1'b0; out2_Tready = 1'b1;
        send(64'h88888888_77777777, 1'b0, cyc);
        step();
        @(negedge aclk);
        chk("t6_sent2", 64'(out2_Tvalid), 64'(0));
        chk("t6_hold1", 64'(out1_Tvalid), 64'(1));
        step();
        aresetn = 1'b0;
        @(negedge aclk);
        chk("t6_v1", 64'(out1_Tvalid), 64'(0));
        chk("t6_v2", 64'(out2_Tvalid), 64'(0));
        chk("t6_rdy", 64'(in1_Tready), 64'(1));
        chk("t6_cnt", 64'(frame_cnt), 64'(0));
        chk("t6_err", 64'(last_err), 64'(0));
        step();
        aresetn = 1'b1; out1_Tready = 1'b1;
        send(64'h66666666_55555555, 1'b0, cyc);
        @(negedge aclk);
        chk("t6_d1", 64'(out1_Tdata), 64'(32'h55555555));
        chk("t6_d2", 64'(out2_Tdata), 64'(32'h66666666));
        chk("t6_va", 64'(out1_Tvalid & out2_Tvalid), 64'(1));
        step();
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
